// File: rtl/connect4_pkg.sv
// connect4_pkg: shared column-select widths, "none" code and index type
package connect4_pkg;
  localparam int NUM_COLS = 7;
  localparam int COL_W = 3;
  localparam logic [COL_W-1:0] COL_NONE = 3'd7;
  typedef logic [COL_W-1:0] col_idx_t;
endpackage

// File: rtl/input_column_decoder_onehot_encoder.sv
// onehot_encoder: combinational OR-tree index encoder with zero and multi-hot flags
module onehot_encoder
  import connect4_pkg::*;
#(
  parameter int N = NUM_COLS,
  parameter int W = COL_W
) (
  input  logic [N-1:0] i_onehot,
  output logic [W-1:0] o_idx,
  output logic         o_is_zero,
  output logic         o_is_multi
);
  always_comb begin
    o_idx = '0;
    for (int k = 0; k < N; k++) o_idx = o_idx | (i_onehot[k] ? W'(k) : W'(0));
  end
  assign o_is_zero = i_onehot == '0;
  // clearing the lowest set bit leaves something only when two or more bits were set
  assign o_is_multi = |(i_onehot & (i_onehot - N'(1)));
endmodule

// File: rtl/input_column_decoder.sv
// input_column_decoder: registers the binary column index decoded from a one-hot select
module input_column_decoder
  import connect4_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_COLS-1:0] in_column,
  output col_idx_t            column_decode,
  output logic                column_valid,
  output logic                column_error
);
  col_idx_t w_idx;
  logic w_zero, w_multi;
  col_idx_t r_decode;
  logic r_valid, r_error;
  onehot_encoder #(.N(NUM_COLS), .W(COL_W)) u_enc (
    .i_onehot  (in_column),
    .o_idx     (w_idx),
    .o_is_zero (w_zero),
    .o_is_multi(w_multi)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decode <= COL_NONE;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_decode <= (w_zero || w_multi) ? COL_NONE : w_idx;
      r_valid  <= !(w_zero || w_multi);
      r_error  <= w_multi;
    end
  end
  assign column_decode = r_decode;
  assign column_valid  = r_valid;
  assign column_error  = r_error;
endmodule

// File: tb/tb_input_column_decoder.sv
// tb_input_column_decoder: directed and random checks against a popcount reference model
module tb_input_column_decoder;
  logic       clk;
  logic       rst_n;
  logic [6:0] in_column;
  logic [2:0] column_decode;
  logic       column_valid;
  logic       column_error;
  int compared = 0;
  int mismatched = 0;
  input_column_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_column    (in_column),
    .column_decode(column_decode),
    .column_valid (column_valid),
    .column_error (column_error)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [4:0] model(input logic [6:0] x);
    int n;
    int pos;
    n = 0;
    pos = 7;
    for (int k = 0; k < 7; k++) if (x[k]) begin
      n++;
      pos = k;
    end
    if (n == 1) return {3'(pos), 2'b10};
    return {3'd7, 1'b0, n > 1};
  endfunction
  task automatic chk(input string tag, input logic [2:0] d, input logic v, input logic e);
    compared++;
    assert ({column_decode, column_valid, column_error} === {d, v, e})
    else begin
      mismatched++;
      $error("FAIL %s: got %0d/%0b/%0b expected %0d/%0b/%0b", tag,
             column_decode, column_valid, column_error, d, v, e);
    end
  endtask
  task automatic step(input string tag, input logic [6:0] x);
    logic [4:0] m;
    in_column = x;
    m = model(x);
    @(posedge clk);
    #1;
    chk(tag, m[4:2], m[1], m[0]);
  endtask
  initial begin
    logic [6:0] r;
    rst_n = 1'b0;
    in_column = 7'b0000001;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 3'd7, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release_no_edge", 3'd7, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_first_edge", 3'd0, 1'b1, 1'b0);
    step("walk_zero", 7'b0);
    for (int i = 0; i < 7; i++) step($sformatf("walk_%0d", i), 7'(1 << i));
    step("pre_zero", 7'b0010000);
    step("zero", 7'b0);
    step("multi_03", 7'b0000011);
    step("multi_41", 7'b1000001);
    step("multi_7f", 7'b1111111);
    step("after_multi", 7'b0001000);
    step("pre_async", 7'b0100000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 3'd7, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("after_async", 7'b0001000);
    in_column = 7'b0100000;
    #3;
    chk("latency_hold", 3'd3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("latency_update", 3'd5, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: r = 7'(1 << $urandom_range(0, 6));
        1: r = 7'b0;
        default: r = 7'($urandom);
      endcase
      step($sformatf("rand_%0d_%07b", i, r), r);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
